// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths, constants and slot-select encoding for the write-port arbiter
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_FIFO,
    SEL_BYP
  } sel_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - in-order MDU result queue with per-entry valid bit, kill-by-address and pending mask
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rwd,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rwd,
  output logic                  head_valid,
  output logic [REG_ADDR_W-1:0] head_rwd,
  output logic [DATA_W-1:0]     head_data,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [REG_ADDR_W-1:0] rwd_q  [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  // Kill runs before pop/push in the block so a recycled slot always ends up with the push's valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && rwd_q[i] == kill_rwd) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        rwd_q[wr_ptr]   <= push_rwd;
        data_q[wr_ptr]  <= push_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_valid = (count != '0) && valid_q[rd_ptr];
  assign head_rwd   = rwd_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pending_mask = pending_mask | reg_onehot(rwd_q[i]);
      end
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: pipeline priority, queued MDU drain, starvation stall
// Optional direct MDU-to-port bypass when WB_BYPASS_EN is defined.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] pipe_rwd,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rwd,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  output logic [REG_ADDR_W-1:0] rf_rwd,
  output logic [DATA_W-1:0]     rf_data,
  output logic                  stall_pipe,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      fifo_count
);

  localparam int STV_W = $clog2(STARVE_LIMIT) + 1;

  sel_e                  sel;
  logic [STV_W-1:0]      starve_cnt;
  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_rwd;
  logic [DATA_W-1:0]     head_data;
  logic                  push_fire;
  logic                  enq;
  logic                  pop;
  logic                  kill_en;

  // Ready reflects current occupancy only; a same-cycle pop never frees a slot early.
  assign mdu_ready = fifo_count < CNT_W'(DEPTH);
  assign push_fire = mdu_valid && mdu_ready;

  always_comb begin
    sel = SEL_NONE;
    if (stall_pipe) begin
      if (head_valid) sel = SEL_FIFO;
    end else if (pipe_rwd != REG_ZERO) begin
      sel = SEL_PIPE;
    end else if (head_valid) begin
      sel = SEL_FIFO;
    end
`ifdef WB_BYPASS_EN
    else if (fifo_count == '0 && push_fire && mdu_rwd != REG_ZERO) begin
      sel = SEL_BYP;
    end
`endif
  end

  // A killed head is discarded without taking the port.
  assign kill_en = (sel == SEL_PIPE);
  assign pop     = (sel == SEL_FIFO) || (fifo_count != '0 && !head_valid);
  assign enq     = push_fire && (mdu_rwd != REG_ZERO) && (sel != SEL_BYP)
                   && !(kill_en && mdu_rwd == pipe_rwd);

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (CLK),
    .rst          (RST),
    .push         (enq),
    .push_rwd     (mdu_rwd),
    .push_data    (mdu_data),
    .pop          (pop),
    .kill_en      (kill_en),
    .kill_rwd     (pipe_rwd),
    .head_valid   (head_valid),
    .head_rwd     (head_rwd),
    .head_data    (head_data),
    .pending_mask (pending_mask),
    .count        (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_rwd     <= REG_ZERO;
      rf_data    <= '0;
      stall_pipe <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (sel)
        SEL_PIPE: begin
          rf_rwd  <= pipe_rwd;
          rf_data <= pipe_data;
        end
        SEL_FIFO: begin
          rf_rwd  <= head_rwd;
          rf_data <= head_data;
        end
        SEL_BYP: begin
          rf_rwd  <= mdu_rwd;
          rf_data <= mdu_data;
        end
        default: begin
          rf_rwd  <= REG_ZERO;
          rf_data <= '0;
        end
      endcase

      stall_pipe <= 1'b0;
      if (head_valid && sel != SEL_FIFO) begin
        if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
          stall_pipe <= 1'b1;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_cnt + STV_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [4:0]       pipe_rwd;
  logic [31:0]      pipe_data;
  logic             mdu_valid;
  logic [4:0]       mdu_rwd;
  logic [31:0]      mdu_data;
  logic             mdu_ready;
  logic [4:0]       rf_rwd;
  logic [31:0]      rf_data;
  logic             stall_pipe;
  logic [31:0]      pending_mask;
  logic [CNT_W-1:0] fifo_count;

  always #5 CLK = ~CLK;

  wb_port_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pipe_rwd     (pipe_rwd),
    .pipe_data    (pipe_data),
    .mdu_valid    (mdu_valid),
    .mdu_rwd      (mdu_rwd),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .rf_rwd       (rf_rwd),
    .rf_data      (rf_data),
    .stall_pipe   (stall_pipe),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  typedef struct {
    logic [4:0]  rwd;
    logic [31:0] data;
    bit          live;
  } entry_t;

  entry_t      mq[$];
  logic [4:0]  m_rf_rwd;
  logic [31:0] m_rf_data;
  bit          m_stall;
  int          m_wait;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rf_rwd  = '0;
    m_rf_data = '0;
    m_stall   = 0;
    m_wait    = 0;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live && mq[i].rwd != 0) m[mq[i].rwd] = 1'b1;
    return m;
  endfunction

  task automatic check_outputs();
    check("rf_rwd", 32'(rf_rwd), 32'(m_rf_rwd));
    check("rf_data", rf_data, m_rf_data);
    check("stall_pipe", 32'(stall_pipe), 32'(m_stall));
    check("pending_mask", pending_mask, model_mask());
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
  endtask

  // One posedge of the arbiter, evaluated from the current model state and inputs.
  task automatic model_step();
    bit          fire, head_ok, take_pipe, take_head, byp, do_pop;
    logic [4:0]  nr;
    logic [31:0] nd;
    bit          ns;
    int          nw;
    fire      = mdu_valid && (mq.size() < DEPTH);
    head_ok   = mq.size() > 0 && mq[0].live;
    take_pipe = 0;
    take_head = 0;
    byp       = 0;
    if (m_stall) take_head = head_ok;
    else if (pipe_rwd != 0) take_pipe = 1;
    else if (head_ok) take_head = 1;
`ifdef WB_BYPASS_EN
    else if (mq.size() == 0 && fire && mdu_rwd != 0) byp = 1;
`endif
    nr = '0;
    nd = '0;
    if (take_pipe) begin nr = pipe_rwd; nd = pipe_data; end
    else if (take_head) begin nr = mq[0].rwd; nd = mq[0].data; end
    else if (byp) begin nr = mdu_rwd; nd = mdu_data; end
    ns = 0;
    nw = 0;
    if (head_ok && !take_head) begin
      if (m_wait == STARVE_LIMIT - 1) ns = 1;
      else nw = m_wait + 1;
    end
    do_pop = mq.size() > 0 && (take_head || !mq[0].live);
    if (take_pipe) foreach (mq[i]) if (mq[i].rwd == pipe_rwd) mq[i].live = 0;
    if (do_pop) void'(mq.pop_front());
    if (fire && mdu_rwd != 0 && !byp && !(take_pipe && mdu_rwd == pipe_rwd))
      mq.push_back('{rwd: mdu_rwd, data: mdu_data, live: 1'b1});
    m_rf_rwd  = nr;
    m_rf_data = nd;
    m_stall   = ns;
    m_wait    = nw;
  endtask

  int busy_pct[6] = '{0, 100, 60, 90, 30, 100};
  int mdu_pct[6]  = '{70, 60, 50, 100, 40, 30};

  initial begin
    RST       = 1'b1;
    pipe_rwd  = '0;
    pipe_data = '0;
    mdu_valid = 1'b0;
    mdu_rwd   = '0;
    mdu_data  = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 300; c++) begin
        bit do_rst;
        bit was_ready;
        @(negedge CLK);
        check_outputs();
        was_ready = mq.size() < DEPTH;
        do_rst    = ($urandom_range(0, 199) == 0);
        if (!m_stall) begin
          pipe_rwd  = ($urandom_range(0, 99) < busy_pct[p]) ? 5'($urandom_range(1, 7)) : 5'd0;
          pipe_data = $urandom;
        end
        if (!(mdu_valid && !was_ready)) begin
          mdu_valid = ($urandom_range(0, 99) < mdu_pct[p]);
          mdu_rwd   = 5'($urandom_range(0, 7));
          mdu_data  = $urandom;
        end
        RST = do_rst;
        if (do_rst) model_reset();
        else model_step();
      end
    end
    @(negedge CLK);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
